// File: rtl/rpn_stack_calc.sv
// Reverse-Polish stack calculator. The top of stack is kept in a register;
// deeper entries live in a single-port synchronous RAM. Commands that need
// the next-on-stack value take a FETCH/EXEC detour through the RAM.
module rpn_stack_calc #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             push,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    cnt,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_NEG  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_DROP = 3'd7;

  localparam logic [1:0] EC_OVF = 2'd1;
  localparam logic [1:0] EC_UDF = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [2:0]       op_q, op_d;
  logic             ready_q, ready_d;

  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    cnt_m1;
  logic [CW-1:0]    cnt_m2;
  logic             is_full;
  logic             is_empty;
  logic             fail;
  logic [1:0]       fail_code;
  logic [WIDTH-1:0] nos;
  logic [WIDTH-1:0] mul_res;

  assign cnt_m1   = cnt_q - CW'(1);
  assign cnt_m2   = cnt_q - CW'(2);
  assign is_full  = (cnt_q == CW'(DEPTH));
  assign is_empty = (cnt_q == CW'(0));
  assign nos      = ram_rdata_q;
  assign mul_res  = nos * top_q;

  assign in_ready = ready_q;
  assign top      = top_q;
  assign cnt      = cnt_q;
  assign err      = err_q;
  assign err_code = err_code_q;

  // Stack RAM: single port, read-first, registered read data.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata_q <= mem[ram_addr];
  end

  // Command decode, precondition checks, FSM next state and error tracking.
  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    ram_we     = 1'b0;
    ram_addr   = cnt_m2[AW-1:0];
    ram_wdata  = top_q;
    fail       = 1'b0;
    fail_code  = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (push) begin
            if (is_full) begin
              fail      = 1'b1;
              fail_code = EC_OVF;
            end else begin
              if (!is_empty) begin
                ram_we   = 1'b1;
                ram_addr = cnt_m1[AW-1:0];
              end else begin
                ram_we   = 1'b0;
              end
              top_d = d;
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            case (op)
              OP_NOP: begin
                state_d = ST_IDLE;
              end
              OP_NEG: begin
                if (is_empty) begin
                  fail      = 1'b1;
                  fail_code = EC_UDF;
                end else begin
                  top_d = -top_q;
                end
              end
              OP_ADD, OP_SUB, OP_MUL, OP_SWAP: begin
                if (cnt_q < CW'(2)) begin
                  fail      = 1'b1;
                  fail_code = EC_UDF;
                end else begin
                  op_d    = op;
                  state_d = ST_FETCH;
                end
              end
              OP_DUP: begin
                if (is_empty) begin
                  fail      = 1'b1;
                  fail_code = EC_UDF;
                end else if (is_full) begin
                  fail      = 1'b1;
                  fail_code = EC_OVF;
                end else begin
                  ram_we   = 1'b1;
                  ram_addr = cnt_m1[AW-1:0];
                  cnt_d    = cnt_q + CW'(1);
                end
              end
              OP_DROP: begin
                if (is_empty) begin
                  fail      = 1'b1;
                  fail_code = EC_UDF;
                end else if (cnt_q == CW'(1)) begin
                  top_d = {WIDTH{1'b0}};
                  cnt_d = CW'(0);
                end else begin
                  op_d    = op;
                  state_d = ST_FETCH;
                end
              end
              default: begin
                state_d = ST_IDLE;
              end
            endcase
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ram_addr = cnt_m2[AW-1:0];
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (op_q)
          OP_ADD: begin
            top_d = nos + top_q;
            cnt_d = cnt_m1;
          end
          OP_SUB: begin
            top_d = nos - top_q;
            cnt_d = cnt_m1;
          end
          OP_MUL: begin
            top_d = mul_res;
            cnt_d = cnt_m1;
          end
          OP_SWAP: begin
            ram_we    = 1'b1;
            ram_addr  = cnt_m2[AW-1:0];
            ram_wdata = top_q;
            top_d     = nos;
          end
          OP_DROP: begin
            top_d = nos;
            cnt_d = cnt_m1;
          end
          default: begin
            top_d = top_q;
          end
        endcase
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A failure on the clearing edge still records itself.
    if (fail) begin
      if (!err_q || clr_err) begin
        err_d      = 1'b1;
        err_code_d = fail_code;
      end else begin
        err_d      = err_q;
        err_code_d = err_code_q;
      end
    end else if (clr_err) begin
      err_d      = 1'b0;
      err_code_d = 2'd0;
    end else begin
      err_d      = err_q;
      err_code_d = err_code_q;
    end

    ready_d = (state_d == ST_IDLE);
  end

  // State, stack-top and error registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      top_q      <= {WIDTH{1'b0}};
      cnt_q      <= CW'(0);
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      op_q       <= 3'd0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      op_q       <= op_d;
      ready_q    <= ready_d;
    end
  end

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Self-checking bench: a 16-bit/1024-deep and an 8-bit/4-deep calculator,
// each compared against a queue-based stack model after every command.
module tb_rpn_stack_calc;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst;

  logic        v_b, p_b, c_b, rdy_b, err_b;
  logic [2:0]  o_b;
  logic [15:0] d_b, top_b;
  logic [10:0] cnt_b;
  logic [1:0]  ec_b;

  logic        v_s, p_s, c_s, rdy_s, err_s;
  logic [2:0]  o_s;
  logic [7:0]  d_s, top_s;
  logic [2:0]  cnt_s;
  logic [1:0]  ec_s;

  rpn_stack_calc #(.WIDTH(16), .DEPTH(1024)) u_big (
    .clk(clk), .nrst(nrst), .in_valid(v_b), .in_ready(rdy_b), .push(p_b),
    .op(o_b), .d(d_b), .clr_err(c_b), .top(top_b), .cnt(cnt_b),
    .err(err_b), .err_code(ec_b));

  rpn_stack_calc #(.WIDTH(8), .DEPTH(4)) u_small (
    .clk(clk), .nrst(nrst), .in_valid(v_s), .in_ready(rdy_s), .push(p_s),
    .op(o_s), .d(d_s), .clr_err(c_s), .top(top_s), .cnt(cnt_s),
    .err(err_s), .err_code(ec_s));

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] qb[$];
  logic [15:0] qs[$];
  bit          m_err[2];
  logic [1:0]  m_code[2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic observe(input bit sel, output logic rdy, output logic [31:0] t,
                         output logic [31:0] c, output logic [31:0] e, output logic [31:0] ec);
    if (sel) begin
      rdy = rdy_s; t = 32'(top_s); c = 32'(cnt_s); e = 32'(err_s); ec = 32'(ec_s);
    end else begin
      rdy = rdy_b; t = 32'(top_b); c = 32'(cnt_b); e = 32'(err_b); ec = 32'(ec_b);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input bit p, input logic [2:0] o,
                       input logic [15:0] dv, input bit clr);
    if (sel) begin
      v_s = v; p_s = p; o_s = o; d_s = dv[7:0]; c_s = clr;
    end else begin
      v_b = v; p_b = p; o_b = o; d_b = dv; c_b = clr;
    end
  endtask

  task automatic reset_models();
    qb.delete(); qs.delete();
    m_err[0] = 1'b0; m_err[1] = 1'b0;
    m_code[0] = 2'd0; m_code[1] = 2'd0;
  endtask

  // Issue one command, update the model, wait for completion, compare.
  task automatic do_cmd(input bit sel, input bit p, input logic [2:0] o,
                        input logic [15:0] dv, input bit clr);
    logic [15:0] q[$];
    logic [15:0] mask, a, b;
    logic [1:0]  fc;
    int          depth, busy, busy_exp;
    logic        rdy;
    logic [31:0] t, c, e, ec, t_exp;
    q     = sel ? qs : qb;
    depth = sel ? 4 : 1024;
    mask  = sel ? 16'h00FF : 16'hFFFF;
    fc    = 2'd0;
    busy_exp = 0;
    if (p) begin
      if (q.size() == depth) fc = 2'd1;
      else q.push_back(dv & mask);
    end else begin
      case (o)
        3'd1: begin
          if (q.size() == 0) fc = 2'd2;
          else q[q.size()-1] = (16'd0 - q[q.size()-1]) & mask;
        end
        3'd2, 3'd3, 3'd4, 3'd6: begin
          if (q.size() < 2) fc = 2'd2;
          else begin
            busy_exp = 2;
            b = q.pop_back();
            a = q.pop_back();
            case (o)
              3'd2: q.push_back((a + b) & mask);
              3'd3: q.push_back((a * b) & mask);
              3'd4: q.push_back((a - b) & mask);
              default: begin q.push_back(b); q.push_back(a); end
            endcase
          end
        end
        3'd5: begin
          if (q.size() == 0) fc = 2'd2;
          else if (q.size() == depth) fc = 2'd1;
          else q.push_back(q[q.size()-1]);
        end
        3'd7: begin
          if (q.size() == 0) fc = 2'd2;
          else begin
            if (q.size() >= 2) busy_exp = 2;
            void'(q.pop_back());
          end
        end
        default: ;
      endcase
    end
    if (fc != 2'd0) begin
      if (!m_err[sel] || clr) begin m_err[sel] = 1'b1; m_code[sel] = fc; end
    end else if (clr) begin
      m_err[sel] = 1'b0; m_code[sel] = 2'd0;
    end
    if (sel) qs = q; else qb = q;
    t_exp = (q.size() > 0) ? 32'(q[q.size()-1]) : 32'd0;

    @(negedge clk);
    drive(sel, 1'b1, p, o, dv, clr);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    busy = 0;
    observe(sel, rdy, t, c, e, ec);
    while (!rdy && busy < 10) begin
      @(posedge clk);
      #1;
      busy++;
      observe(sel, rdy, t, c, e, ec);
    end
    check("busy_cycles", 32'(busy), 32'(busy_exp));
    check("top", t, t_exp);
    check("cnt", c, 32'(q.size()));
    check("err", e, 32'(m_err[sel]));
    check("err_code", ec, 32'(m_code[sel]));
  endtask

  initial begin
    logic        rdy;
    logic [31:0] t, c, e, ec;
    int          r;
    nrst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    reset_models();
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      observe(s[0], rdy, t, c, e, ec);
      check("rst_ready", 32'(rdy), 32'd1);
      check("rst_top", t, 32'd0);
      check("rst_cnt", c, 32'd0);
      check("rst_err", e + ec, 32'd0);
    end

    // Arithmetic basics on the 16-bit unit.
    do_cmd(1'b0, 1'b1, 3'd0, 16'd3, 1'b0);
    do_cmd(1'b0, 1'b1, 3'd0, 16'd4, 1'b0);
    do_cmd(1'b0, 1'b0, 3'd2, 16'd0, 1'b0);
    check("add_7", 32'(top_b), 32'd7);
    do_cmd(1'b0, 1'b0, 3'd7, 16'd0, 1'b0);
    do_cmd(1'b0, 1'b1, 3'd0, 16'd5, 1'b0);
    do_cmd(1'b0, 1'b1, 3'd0, 16'd9, 1'b0);
    do_cmd(1'b0, 1'b0, 3'd4, 16'd0, 1'b0);
    check("sub_neg4", 32'(top_b), 32'h0000FFFC);
    do_cmd(1'b0, 1'b1, 3'd0, 16'd6, 1'b0);
    do_cmd(1'b0, 1'b0, 3'd3, 16'd0, 1'b0);
    check("mul_neg24", 32'(top_b), 32'h0000FFE8);
    check("mul_cnt", 32'(cnt_b), 32'd1);
    do_cmd(1'b0, 1'b0, 3'd7, 16'd0, 1'b0);
    do_cmd(1'b0, 1'b1, 3'd0, 16'h8000, 1'b0);
    do_cmd(1'b0, 1'b0, 3'd1, 16'd0, 1'b0);
    check("neg_minval", 32'(top_b), 32'h00008000);
    check("neg_no_err", 32'(err_b), 32'd0);
    do_cmd(1'b0, 1'b1, 3'd0, 16'd1, 1'b0);
    do_cmd(1'b0, 1'b1, 3'd0, 16'd2, 1'b0);
    do_cmd(1'b0, 1'b0, 3'd6, 16'd0, 1'b0);
    do_cmd(1'b0, 1'b0, 3'd7, 16'd0, 1'b0);
    check("swapdrop_top", 32'(top_b), 32'd2);
    check("swapdrop_cnt", 32'(cnt_b), 32'd2);
    do_cmd(1'b0, 1'b0, 3'd7, 16'd0, 1'b0);
    do_cmd(1'b0, 1'b0, 3'd7, 16'd0, 1'b0);

    // Underflow and sticky first error.
    do_cmd(1'b0, 1'b0, 3'd2, 16'd0, 1'b0);
    check("udf_code", 32'(ec_b), 32'd2);
    do_cmd(1'b0, 1'b0, 3'd1, 16'd0, 1'b0);
    do_cmd(1'b0, 1'b1, 3'd0, 16'd1, 1'b0);
    do_cmd(1'b0, 1'b0, 3'd7, 16'd0, 1'b0);
    do_cmd(1'b0, 1'b0, 3'd0, 16'd0, 1'b1);

    // Overflow on the 4-deep unit, then clear.
    for (int i = 0; i < 4; i++) do_cmd(1'b1, 1'b1, 3'd0, 16'(i + 1), 1'b0);
    do_cmd(1'b1, 1'b1, 3'd0, 16'h0055, 1'b0);
    check("ovf_code", 32'(ec_s), 32'd1);
    check("ovf_top", 32'(top_s), 32'd4);
    do_cmd(1'b1, 1'b0, 3'd0, 16'd0, 1'b1);
    check("clr_err", 32'(err_s), 32'd0);

    // Random traffic on the small unit (hits both bounds often).
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      do_cmd(1'b1, (r < 4), 3'($urandom_range(0, 7)), 16'($urandom),
             ($urandom_range(0, 9) == 0));
    end

    // Reset while an ADD sits in FETCH.
    do_cmd(1'b0, 1'b1, 3'd0, 16'd10, 1'b0);
    do_cmd(1'b0, 1'b1, 3'd0, 16'd20, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'd2, 16'd0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
    check("fetch_busy", 32'(rdy_b), 32'd0);
    #2;
    nrst = 1'b0;
    #1;
    check("midrst_top", 32'(top_b), 32'd0);
    check("midrst_cnt", 32'(cnt_b), 32'd0);
    check("midrst_ready", 32'(rdy_b), 32'd1);
    reset_models();
    @(negedge clk);
    nrst = 1'b1;
    do_cmd(1'b0, 1'b1, 3'd0, 16'd1, 1'b0);
    check("postrst_top", 32'(top_b), 32'd1);

    // Random traffic on the wide unit.
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      do_cmd(1'b0, (r < 5), 3'($urandom_range(0, 7)), 16'($urandom),
             ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
